// File: rtl/lsu_bus_ctrl_if.sv
// Valid/ready data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: turns core load/store controls into byte-lane bus requests,
// stalls the core until the access completes and returns extended load data.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemRead,
  input  logic           MemWrite,
  input  logic [2:0]     Funct3,
  input  logic [31:0]    Mem_WrAddr,
  input  logic [31:0]    Mem_WrData,
  output logic [31:0]    ReadData,
  output logic           Stall,
  output logic           MisalignErr,
  output logic           BusErr,
  lsu_bus_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic [31:0]     data_q, data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;

  logic            access, size_ok, illegal, legal;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h0, b};
      3'b101:  extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  always_comb begin
    access = MemRead | MemWrite;
    case (Funct3)
      3'b000, 3'b100: size_ok = 1'b1;
      3'b001, 3'b101: size_ok = ~Mem_WrAddr[0];
      3'b010:         size_ok = (Mem_WrAddr[1:0] == 2'b00);
      default:        size_ok = 1'b0;
    endcase
    illegal = ~size_ok | (MemRead & MemWrite);
    legal   = access & ~illegal;

    // Store lanes follow the access size; loads always fetch the whole word.
    case (Funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << Mem_WrAddr[1:0];
        wdata_new = {4{Mem_WrData[7:0]}};
      end
      2'b01: begin
        be_new    = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{Mem_WrData[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = Mem_WrData;
      end
    endcase
    if (!MemWrite) be_new = 4'b1111;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (legal) begin
          state_d = S_REQ;
          we_d    = MemWrite;
          addr_d  = {Mem_WrAddr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = Funct3;
          lo_d    = Mem_WrAddr[1:0];
        end
      end
      S_REQ: begin
        // A response only counts once the request has been accepted.
        if (bus.bus_ready) begin
          cnt_d = '0;
          if (bus.bus_rvalid) begin
            state_d = S_DONE;
            if (!we_q) data_d = extract(bus.bus_rdata, f3_q, lo_q);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.bus_rvalid) begin
          state_d = S_DONE;
          if (!we_q) data_d = extract(bus.bus_rdata, f3_q, lo_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          data_d    = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.bus_req   = (state_q == S_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  // Stall is held low while reset is asserted even if a load is being presented.
  assign Stall       = reset & (((state_q == S_IDLE) & legal) | (state_q == S_REQ) |
                                (state_q == S_WAIT));
  assign MisalignErr = access & illegal;
  assign BusErr      = bus_err_q;
  assign ReadData    = ((state_q == S_IDLE) & MisalignErr & MemRead) ? 32'h0 : data_q;

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store unit between the single-cycle core's datapath and a handshaked data-memory bus. It takes the datapath's memory address/write-data and the decoder's load/store controls. It generates byte-lane requests on a valid/ready bus, and holds the core via Stall until the access completes. It then returns sign/zero-extended load data as the datapath's ReadData.

Parameters:
TIMEOUT, 16, max cycles waiting for bus_rvalid after acceptance before aborting with BusErr
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  current instruction is a load
MemWrite  input  1  current instruction is a store
Funct3  input  3  load/store size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
Mem_WrAddr  input  32  byte address from datapath ALU result
Mem_WrData  input  32  store data from datapath rs2
ReadData  output  32  extended load data to datapath result mux
Stall  output  1  holds PC and register-file write while high
MisalignErr  output  1  combinational: access misaligned or illegal Funct3
BusErr  output  1  one-cycle pulse on timeout
bus_req  output  1  request valid
bus_we  output  1  1 = write
bus_addr  output  32  word address, {Mem_WrAddr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ready  input  1  slave accepts request this cycle
bus_rvalid  input  1  response/completion (reads and writes)
bus_rdata  input  32  read word

Behaviour:
- Reset (reset low, async): state IDLE; bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0; data register 0; counter 0; BusErr 0. ReadData 0, Stall 0.
- access = MemRead|MemWrite. The request fields (we, addr, be, wdata, Funct3, addr[1:0]) are latched on leaving IDLE. They stay stable while bus_req is high.
- Misalign/illegal: Funct3 011/110/111; H/HU with addr[0]=1; W with addr[1:0]!=0. With access asserted, MisalignErr=1, no bus access, Stall=0, and a load returns ReadData=0. MemRead and MemWrite both high is illegal and is treated the same way.
- States:
  - IDLE: on a legal access, go to REQ. Stall=1 combinationally in this same cycle.
  - REQ: bus_req=1. On bus_ready, go to WAIT. If bus_rvalid is also high in that cycle, go directly to DONE and capture the data. bus_rvalid before acceptance is ignored.
  - WAIT: counter increments each cycle. On bus_rvalid, capture bus_rdata and go to DONE. If the counter reaches TIMEOUT-1 without bus_rvalid, pulse BusErr, set the data register to 0, and go to DONE.
  - DONE: Stall=0, so the instruction retires this cycle with ReadData valid. Next state is always IDLE. DONE must not re-trigger on the same instruction.
- Stall = (IDLE & legal access) | REQ | WAIT.
- Minimum latency: 2 stall cycles (IDLE→REQ with same-cycle ready+rvalid→DONE). Retire occurs in the DONE cycle.
- Stores:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111.
  - Loads drive be = 1111.
- Load extraction uses the latched addr[1:0] and Funct3:
  - B/BU select byte lane addr[1:0].
  - H/HU select the half at addr[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
- ReadData is the extracted value while in DONE, and the registered value otherwise.
- Reset asserted mid-transaction aborts immediately to IDLE with bus_req dropped. A late bus_rvalid after reset is ignored.
- Counter clears on every entry to WAIT.

Test Plan:
- LW at 0x100, slave ready+rvalid in the REQ cycle with rdata 0xDEADBEEF → Stall high 2 cycles, DONE ReadData=0xDEADBEEF, bus_be=1111, bus_addr=0x100.
- LB at 0x103, rdata 0x80FF0000, ready after 2 cycles, rvalid 3 cycles later → ReadData=0xFFFFFF80. The same access as LBU → 0x00000080. Stall covers every wait cycle.
- SH at 0x202, data 0x1234ABCD → bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0xABCDABCD, no ReadData change.
- LW at 0x101, and separately Funct3=011 → MisalignErr=1, bus_req never asserted, Stall=0.
- Load accepted, no rvalid for TIMEOUT=16 cycles → single BusErr pulse, DONE with ReadData=0, then IDLE.
- Reset asserted in WAIT, then rvalid arrives → outputs return to reset values immediately, and the rvalid is ignored (state stays IDLE).
